// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - ST7920 parallel bus owner: power-up/init sequencer plus two-client round-robin arbiter with line locking
module lcd_bus_arbiter #(
  parameter int RST_CYC   = 500000,
  parameter int PWRUP_CYC = 2000000,
  parameter int T_SU      = 4,
  parameter int T_PW      = 32,
  parameter int T_HD      = 4,
  parameter int T_EXEC    = 3600,
  parameter int T_CLR     = 80000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c0_valid,
  input  logic       c0_rs,
  input  logic [7:0] c0_dat,
  input  logic       c0_last,
  output logic       c0_ready,
  input  logic       c1_valid,
  input  logic       c1_rs,
  input  logic [7:0] c1_dat,
  input  logic       c1_last,
  output logic       c1_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       lcd_rst,
  output logic       psb,
  output logic       init_done,
  output logic       busy
);

  localparam int MAX_A = (RST_CYC > PWRUP_CYC) ? RST_CYC : PWRUP_CYC;
  localparam int MAX_B = (MAX_A > T_CLR) ? MAX_A : T_CLR;
  localparam int MAX_C = (MAX_B > T_EXEC) ? MAX_B : T_EXEC;
  localparam int MAX_N = (MAX_C > T_PW) ? MAX_C : T_PW;
  localparam int CW    = $clog2(MAX_N + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RST_LAST   = cnt_t'(RST_CYC - 1);
  localparam cnt_t PWRUP_LAST = cnt_t'(PWRUP_CYC - 1);
  localparam cnt_t SU_LAST    = cnt_t'(T_SU - 1);
  localparam cnt_t PW_LAST    = cnt_t'(T_PW - 1);
  localparam cnt_t HD_LAST    = cnt_t'(T_HD - 1);
  localparam cnt_t EXEC_LAST  = cnt_t'(T_EXEC - 1);
  localparam cnt_t CLR_LAST   = cnt_t'(T_CLR - 1);

  typedef enum logic [2:0] {
    RSTLOW, PWRUP, INIT_LOAD, SU, PW, HD, WAIT, IDLE
  } state_t;

  state_t     state_q;
  cnt_t       cnt_q;
  logic [2:0] idx_q;
  logic       init_done_q;
  logic       busy_q;
  logic       lcd_en_q;
  logic       lcd_rs_q;
  logic [7:0] lcd_dat_q;
  logic       lcd_rst_q;
  logic       c0_ready_q;
  logic       c1_ready_q;
  logic       owner_vld_q;
  logic       owner_q;
  logic       last_served_q;

  logic       req0_d;
  logic       req1_d;
  logic       gnt0_d;
  logic       gnt1_d;
  logic       is_clr;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h30;
      3'd1:    return 8'h30;
      3'd2:    return 8'h0C;
      3'd3:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // The captured byte stays on the bus through WAIT, so it selects the wait length directly.
  assign is_clr = !lcd_rs_q && (lcd_dat_q == 8'h01);

  always_comb begin
    req0_d = 1'b0;
    req1_d = 1'b0;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (state_q == IDLE) begin
      req0_d = c0_valid && (!owner_vld_q || !owner_q);
      req1_d = c1_valid && (!owner_vld_q ||  owner_q);
      if (req0_d && req1_d) begin
        gnt0_d =  last_served_q;
        gnt1_d = !last_served_q;
      end else begin
        gnt0_d = req0_d;
        gnt1_d = req1_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RSTLOW;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b1;
      lcd_en_q      <= 1'b0;
      lcd_rs_q      <= 1'b0;
      lcd_dat_q     <= 8'h00;
      lcd_rst_q     <= 1'b0;
      c0_ready_q    <= 1'b0;
      c1_ready_q    <= 1'b0;
      owner_vld_q   <= 1'b0;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
    end else begin
      c0_ready_q <= 1'b0;
      c1_ready_q <= 1'b0;
      case (state_q)
        RSTLOW: begin
          if (cnt_q == RST_LAST) begin
            cnt_q     <= '0;
            lcd_rst_q <= 1'b1;
            state_q   <= PWRUP;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        PWRUP: begin
          if (cnt_q == PWRUP_LAST) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            state_q <= INIT_LOAD;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        INIT_LOAD: begin
          lcd_rs_q  <= 1'b0;
          lcd_dat_q <= init_rom(idx_q);
          cnt_q     <= '0;
          state_q   <= SU;
        end
        SU: begin
          if (cnt_q == SU_LAST) begin
            cnt_q    <= '0;
            lcd_en_q <= 1'b1;
            state_q  <= PW;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        PW: begin
          if (cnt_q == PW_LAST) begin
            cnt_q    <= '0;
            lcd_en_q <= 1'b0;
            state_q  <= HD;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        HD: begin
          if (cnt_q == HD_LAST) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        WAIT: begin
          if (cnt_q == (is_clr ? CLR_LAST : EXEC_LAST)) begin
            cnt_q <= '0;
            if (!init_done_q && (idx_q < 3'd4)) begin
              idx_q   <= idx_q + 3'd1;
              state_q <= INIT_LOAD;
            end else begin
              init_done_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        IDLE: begin
          if (gnt0_d || gnt1_d) begin
            c0_ready_q    <= gnt0_d;
            c1_ready_q    <= gnt1_d;
            lcd_rs_q      <= gnt1_d ? c1_rs  : c0_rs;
            lcd_dat_q     <= gnt1_d ? c1_dat : c0_dat;
            last_served_q <= gnt1_d;
            owner_q       <= gnt1_d;
            owner_vld_q   <= gnt1_d ? !c1_last : !c0_last;
            busy_q        <= 1'b1;
            cnt_q         <= '0;
            state_q       <= SU;
          end
        end
        default: state_q <= RSTLOW;
      endcase
    end
  end

  assign c0_ready  = c0_ready_q;
  assign c1_ready  = c1_ready_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = lcd_en_q;
  assign lcd_dat   = lcd_dat_q;
  assign lcd_rst   = lcd_rst_q;
  assign psb       = 1'b1;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - directed self-checking bench for lcd_bus_arbiter
module tb_lcd_bus_arbiter;

  localparam int RST_CYC   = 10;
  localparam int PWRUP_CYC = 20;
  localparam int T_SU      = 2;
  localparam int T_PW      = 4;
  localparam int T_HD      = 2;
  localparam int T_EXEC    = 10;
  localparam int T_CLR     = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       c0_valid = 1'b0, c0_rs = 1'b0, c0_last = 1'b0;
  logic [7:0] c0_dat = 8'h00;
  logic       c1_valid = 1'b0, c1_rs = 1'b0, c1_last = 1'b0;
  logic [7:0] c1_dat = 8'h00;
  logic       c0_ready, c1_ready;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_rst, psb, init_done, busy;
  logic [7:0] lcd_dat;

  int   errors = 0;
  int   checks = 0;
  logic early_rdy = 1'b0;

  lcd_bus_arbiter #(
    .RST_CYC(RST_CYC), .PWRUP_CYC(PWRUP_CYC), .T_SU(T_SU), .T_PW(T_PW),
    .T_HD(T_HD), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_valid(c0_valid), .c0_rs(c0_rs), .c0_dat(c0_dat), .c0_last(c0_last), .c0_ready(c0_ready),
    .c1_valid(c1_valid), .c1_rs(c1_rs), .c1_dat(c1_dat), .c1_last(c1_last), .c1_ready(c1_ready),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat),
    .lcd_rst(lcd_rst), .psb(psb), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if ((c0_ready || c1_ready) && !init_done) early_rdy = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return lcd_en;
      1:       return lcd_rst;
      2:       return init_done;
      3:       return busy;
      default: return c0_ready | c1_ready;
    endcase
  endfunction

  // Counts falling clock edges until the selected signal reaches lvl.
  task automatic wait_for(input int sel, input logic lvl, input string tag, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (pick(sel) === lvl) return;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_init();
    int n;
    int gap;
    logic [7:0] rom [5];
    rom = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06};
    wait_for(1, 1'b1, "rst_rise", n);
    check("rst_rise_cyc", n, RST_CYC);
    gap = PWRUP_CYC + 1 + T_SU;
    for (int i = 0; i < 5; i++) begin
      wait_for(0, 1'b1, "init_en", n);
      check($sformatf("init%0d_gap", i), n, gap);
      check($sformatf("init%0d_dat", i), lcd_dat, rom[i]);
      check($sformatf("init%0d_rs", i), lcd_rs, 0);
      wait_for(0, 1'b0, "init_pw", n);
      check($sformatf("init%0d_pw", i), n, T_PW);
      gap = T_HD + 1 + T_SU + ((rom[i] == 8'h01) ? T_CLR : T_EXEC);
    end
    wait_for(2, 1'b1, "init_done", n);
    check("init_done_cyc", n, T_HD + T_EXEC);
    check("no_early_ready", early_rdy, 0);
  endtask

  initial begin
    int n;
    int who;
    logic [7:0] lk_dat [3];
    logic       lk_last [3];
    int         lk_i;
    lk_dat  = '{8'h31, 8'h32, 8'h33};
    lk_last = '{1'b0, 1'b0, 1'b1};

    #3 rst_n = 1'b0;
    c0_valid = 1'b1; c0_rs = 1'b1; c0_dat = 8'h41; c0_last = 1'b1;
    c1_valid = 1'b1; c1_rs = 1'b1; c1_dat = 8'h42; c1_last = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_dat", lcd_dat, 0);
    check("rst_lcdrst", lcd_rst, 0);
    check("rst_psb", psb, 1);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 1);
    check("rst_rdy", {c0_ready, c1_ready}, 0);
    rst_n = 1'b1;
    run_init();

    // First grant: c0 wins since last_served resets to 1; check transfer timing.
    wait_for(4, 1'b1, "g0", n);
    check("g0_gap", n, 1);
    check("g0_who", {c0_ready, c1_ready}, 2'b10);
    check("g0_cap_dat", lcd_dat, 8'h41);
    @(negedge clk);
    check("g0_rdy_pulse", c0_ready, 0);
    wait_for(0, 1'b1, "g0_su", n);
    check("g0_su", n, T_SU - 1);
    check("g0_rs", lcd_rs, 1);
    wait_for(0, 1'b0, "g0_pw", n);
    check("g0_pw", n, T_PW);
    for (int i = 0; i < T_HD; i++) begin
      @(negedge clk);
      check($sformatf("g0_hold_dat%0d", i), lcd_dat, 8'h41);
      check($sformatf("g0_hold_rs%0d", i), lcd_rs, 1);
    end
    wait_for(3, 1'b0, "g0_wait", n);
    check("g0_wait", n, T_EXEC);

    for (int i = 1; i < 4; i++) begin
      wait_for(4, 1'b1, "rr", n);
      who = c1_ready ? 1 : 0;
      check($sformatf("rr%0d_onehot", i), c0_ready & c1_ready, 0);
      check($sformatf("rr%0d_who", i), who, i % 2);
      check($sformatf("rr%0d_dat", i), lcd_dat, (i % 2) ? 8'h42 : 8'h41);
      if (i == 1) check("rr1_gap", n, 1);
    end

    c0_dat = lk_dat[0]; c0_last = lk_last[0];
    c1_dat = 8'h55;
    lk_i = 0;
    for (int i = 0; i < 4; i++) begin
      wait_for(4, 1'b1, "lk", n);
      who = c1_ready ? 1 : 0;
      check($sformatf("lk%0d_who", i), who, (i < 3) ? 0 : 1);
      check($sformatf("lk%0d_dat", i), lcd_dat, (i < 3) ? lk_dat[i] : 8'h55);
      if (who == 0) begin
        lk_i++;
        if (lk_i == 3) c0_valid = 1'b0;
        else begin c0_dat = lk_dat[lk_i]; c0_last = lk_last[lk_i]; end
      end else begin
        c1_valid = 1'b0;
      end
    end

    for (int k = 0; k < 2; k++) begin
      c1_valid = 1'b1; c1_rs = (k == 1); c1_dat = 8'h01; c1_last = 1'b1;
      wait_for(4, 1'b1, "clr", n);
      check($sformatf("clr%0d_who", k), c1_ready, 1);
      c1_valid = 1'b0;
      wait_for(0, 1'b1, "clr_en_hi", n);
      wait_for(0, 1'b0, "clr_en_lo", n);
      wait_for(3, 1'b0, "clr_busy", n);
      check($sformatf("clr%0d_busy_len", k), n, T_HD + ((k == 0) ? T_CLR : T_EXEC));
    end

    c0_valid = 1'b1; c0_rs = 1'b1; c0_dat = 8'h77; c0_last = 1'b1;
    wait_for(4, 1'b1, "mr", n);
    c0_valid = 1'b0;
    wait_for(0, 1'b1, "mr_en", n);
    check("mr_en_high", lcd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_en", lcd_en, 0);
    check("mr_lcdrst", lcd_rst, 0);
    check("mr_init_done", init_done, 0);
    check("mr_busy", busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_init();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
